// File: rtl/swipt_carrier_rx.sv
// Receive-side carrier monitor for the SWIPT link.
// Measures the carrier period in clk cycles and qualifies the carrier as
// locked or lost. It also averages the last four good periods and produces
// a heartbeat toggle while locked.
// period_valid and avg_valid are single-cycle strobes with no ready
// signal: a consumer must capture period / period_avg in the pulse cycle.
// state_dbg exposes the FSM state (0 = IDLE, 1 = ACQ, 2 = LOCKED).
module swipt_carrier_rx #(
    parameter int PER_W      = 16,
    parameter int MIN_PER    = 500,
    parameter int MAX_PER    = 5000,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 8192,
    parameter int HB_PERIODS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             carrier_in,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic [PER_W-1:0] period_avg,
    output logic             avg_valid,
    output logic             locked,
    output logic             carrier_lost,
    output logic             heartbeat,
    output logic [7:0]       err_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int HB_W   = $clog2(HB_PERIODS + 1);
    localparam logic [PER_W-1:0] TIMEOUT_V = PER_W'(TIMEOUT);
    localparam logic [PER_W-1:0] MIN_V     = PER_W'(MIN_PER);
    localparam logic [PER_W-1:0] MAX_V     = PER_W'(MAX_PER);

    logic             sync1_q, sync2_q, sync3_q;
    logic             rise;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic             in_range;
    state_t           state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic             bad_q, bad_d;
    logic             lost_q, lost_d;
    logic [7:0]       err_q, err_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             pvalid_q, pvalid_d;
    logic             idle_entry;
    logic [PER_W-1:0] sh_q [4];
    logic [2:0]       fill_q;
    logic             shifted_q;
    logic [PER_W+1:0] sum_q;
    logic             avg_valid_q;
    logic [HB_W-1:0]  hb_cnt_q;
    logic             hb_q;

    // Two-flop synchronizer plus a third flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= carrier_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise     = sync2_q & ~sync3_q;
    assign in_range = (cnt_q >= MIN_V) && (cnt_q <= MAX_V);

    // Period counter: restarts at 1 on an edge, otherwise saturates at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = PER_W'(1);
        end else if (cnt_q != TIMEOUT_V) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Qualification FSM: next state, counters and the period register.
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        bad_d      = bad_q;
        lost_d     = lost_q;
        err_d      = err_q;
        period_d   = period_q;
        pvalid_d   = 1'b0;
        idle_entry = 1'b0;
        if (rise) begin
            lost_d = 1'b0;
            case (state_q)
                IDLE: begin
                    // First edge only opens the measurement window.
                    state_d = ACQ;
                    good_d  = '0;
                    bad_d   = 1'b0;
                end
                ACQ: begin
                    if (in_range) begin
                        pvalid_d = 1'b1;
                        period_d = cnt_q;
                        if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            bad_d   = 1'b0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (in_range) begin
                        pvalid_d = 1'b1;
                        period_d = cnt_q;
                        bad_d    = 1'b0;
                    end else begin
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 1'b1;
                        end
                        if (bad_q) begin
                            // Two bad periods in a row: fall back to acquisition.
                            state_d = ACQ;
                            good_d  = '0;
                            bad_d   = 1'b0;
                        end else begin
                            bad_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (cnt_q == TIMEOUT_V) begin
            state_d    = IDLE;
            lost_d     = 1'b1;
            good_d     = '0;
            bad_d      = 1'b0;
            idle_entry = 1'b1;
        end
    end

    // Counter, FSM and measurement registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            state_q  <= IDLE;
            good_q   <= '0;
            bad_q    <= 1'b0;
            lost_q   <= 1'b0;
            err_q    <= '0;
            period_q <= '0;
            pvalid_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            lost_q   <= lost_d;
            err_q    <= err_d;
            period_q <= period_d;
            pvalid_q <= pvalid_d;
        end
    end

    // Averager: shift on period_valid, register the sum one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                sh_q[i] <= '0;
            end
            fill_q      <= '0;
            shifted_q   <= 1'b0;
            sum_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            shifted_q   <= pvalid_q;
            avg_valid_q <= shifted_q && (fill_q == 3'd4);
            if (shifted_q && (fill_q == 3'd4)) begin
                sum_q <= {2'b00, sh_q[0]} + {2'b00, sh_q[1]}
                       + {2'b00, sh_q[2]} + {2'b00, sh_q[3]};
            end
            if (idle_entry) begin
                fill_q <= '0;
            end else if (pvalid_q) begin
                sh_q[0] <= period_q;
                sh_q[1] <= sh_q[0];
                sh_q[2] <= sh_q[1];
                sh_q[3] <= sh_q[2];
                if (fill_q != 3'd4) begin
                    fill_q <= fill_q + 3'd1;
                end
            end
        end
    end

    // Heartbeat: count good periods while locked, toggle every HB_PERIODS.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else if (state_q != LOCKED) begin
            hb_cnt_q <= '0;
        end else if (pvalid_q) begin
            if (hb_cnt_q == HB_W'(HB_PERIODS - 1)) begin
                hb_cnt_q <= '0;
                hb_q     <= ~hb_q;
            end else begin
                hb_cnt_q <= hb_cnt_q + 1'b1;
            end
        end
    end

    assign period       = period_q;
    assign period_valid = pvalid_q;
    assign period_avg   = sum_q[PER_W+1:2];
    assign avg_valid    = avg_valid_q;
    assign locked       = (state_q == LOCKED);
    assign carrier_lost = lost_q;
    assign heartbeat    = hb_q;
    assign err_cnt      = err_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_swipt_carrier_rx.sv
// Bench for swipt_carrier_rx: directed scenarios plus a randomized tail,
// all compared every cycle against an edge-timestamp model of the carrier
// monitor, with literal expectations at key points.
`timescale 1ns/1ps
module tb_swipt_carrier_rx;

    localparam int PER_W      = 16;
    localparam int MIN_PER    = 500;
    localparam int MAX_PER    = 5000;
    localparam int LOCK_CNT   = 4;
    localparam int TIMEOUT    = 8192;
    localparam int HB_PERIODS = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic carrier_in = 1'b0;
    logic [PER_W-1:0] period, period_avg;
    logic period_valid, avg_valid, locked, carrier_lost, heartbeat;
    logic [7:0] err_cnt;
    logic [1:0] state_dbg;

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    swipt_carrier_rx #(
        .PER_W(PER_W), .MIN_PER(MIN_PER), .MAX_PER(MAX_PER),
        .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .HB_PERIODS(HB_PERIODS)
    ) dut (
        .clk(clk), .rst(rst), .carrier_in(carrier_in),
        .period(period), .period_valid(period_valid),
        .period_avg(period_avg), .avg_valid(avg_valid),
        .locked(locked), .carrier_lost(carrier_lost),
        .heartbeat(heartbeat), .err_cnt(err_cnt), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode: 0 idle, 1 acquiring, 2 locked. Periods are differences of
    // edge timestamps; the carrier is seen two samples late (synchronizer).
    int m_mode, m_good, m_bad, m_err, m_period, m_pv, m_lost;
    int m_hb, m_hbcnt, m_fill, m_avg, m_av, m_ref;
    int h1, h2, h3;
    int p1v, p1val, p2v, p2val;
    int mp, mm, msum;
    bit m_edge, m_inr;
    int last4[$];

    always @(posedge clk) begin
        mp = cyc + 1;
        if (rst) begin
            m_mode = 0; m_good = 0; m_bad = 0; m_err = 0; m_period = 0;
            m_pv = 0; m_lost = 0; m_hb = 0; m_hbcnt = 0; m_fill = 0;
            m_avg = 0; m_av = 0; p1v = 0; p2v = 0; p1val = 0; p2val = 0;
            h1 = 0; h2 = 0; h3 = 0; m_ref = mp;
        end else begin
            // heartbeat follows the previous cycle's pulse and lock status
            if (m_mode != 2) m_hbcnt = 0;
            else if (m_pv != 0) begin
                m_hbcnt++;
                if (m_hbcnt == HB_PERIODS) begin
                    m_hbcnt = 0;
                    m_hb ^= 1;
                end
            end
            // average appears two cycles after its period pulse
            m_av = p2v;
            if (p2v != 0) m_avg = p2val;
            p2v = p1v; p2val = p1val; p1v = 0;

            m_edge = (h2 != 0) && (h3 == 0);
            m_pv = 0;
            if (m_edge) begin
                mm = mp - 1 - m_ref;
                if (mm > TIMEOUT) mm = TIMEOUT;
                m_ref = mp - 1;
                m_lost = 0;
                m_inr = (mm >= MIN_PER) && (mm <= MAX_PER);
                if (m_mode == 0) begin
                    m_mode = 1; m_good = 0; m_bad = 0;
                end else if (m_mode == 1) begin
                    if (m_inr) begin
                        m_pv = 1; m_period = mm; m_good++;
                        if (m_good == LOCK_CNT) begin
                            m_mode = 2; m_bad = 0;
                        end
                    end else m_good = 0;
                end else begin
                    if (m_inr) begin
                        m_pv = 1; m_period = mm; m_bad = 0;
                    end else begin
                        if (m_err < 255) m_err++;
                        m_bad++;
                        if (m_bad == 2) begin
                            m_mode = 1; m_good = 0; m_bad = 0;
                        end
                    end
                end
            end else if (mp - 1 - m_ref >= TIMEOUT) begin
                m_mode = 0; m_lost = 1; m_good = 0; m_bad = 0; m_fill = 0;
            end
            if (m_pv != 0) begin
                last4.push_back(m_period);
                if (last4.size() > 4) void'(last4.pop_front());
                if (m_fill < 4) m_fill++;
                if (m_fill == 4) begin
                    msum = 0;
                    foreach (last4[i]) msum += last4[i];
                    p1v = 1;
                    p1val = msum / 4;
                end
            end
            h3 = h2; h2 = h1; h1 = int'(carrier_in);
        end
    end

    // ---------------- per-cycle compare ----------------
    int pv_seen = 0;
    always @(negedge clk) begin
        if (period_valid === 1'b1) pv_seen <= pv_seen + 1;
        if (cmp_en) begin
            check("period", period, m_period);
            check("period_valid", period_valid, m_pv);
            check("period_avg", period_avg, m_avg);
            check("avg_valid", avg_valid, m_av);
            check("locked", locked, (m_mode == 2) ? 1 : 0);
            check("carrier_lost", carrier_lost, m_lost);
            check("heartbeat", heartbeat, m_hb);
            check("err_cnt", err_cnt, m_err);
            check("state", state_dbg, m_mode);
        end
    end

    // ---------------- driver tasks ----------------
    int last_rise = 0;
    int pv_base = 0;
    int rp = 0;

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Next rising edge exactly per cycles after the previous one.
    task automatic next_edge(input int per);
        wait_to(last_rise + per / 2);
        carrier_in = 1'b0;
        wait_to(last_rise + per);
        carrier_in = 1'b1;
        last_rise = last_rise + per;
    endtask

    task automatic settle();
        wait_to(last_rise + 6);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, period, 0);
        check({tag, "_pvalid"}, period_valid, 0);
        check({tag, "_avg"}, period_avg, 0);
        check({tag, "_avg_valid"}, avg_valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_lost"}, carrier_lost, 0);
        check({tag, "_hb"}, heartbeat, 0);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        carrier_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cmp_en = 1;
        check_all_zero("reset");
        rst = 1'b0;
        wait_to(cyc + 1);
        check_all_zero("post_release");

        // 40 kHz carrier, ten rising edges
        wait_to(cyc + 10);
        carrier_in = 1'b1;
        last_rise = cyc;
        pv_base = pv_seen;
        for (int i = 2; i <= 10; i++) begin
            next_edge(1250);
            settle();
            if (i == 4) begin
                check("lock_edge4", locked, 0);
                check("avg_edge4", period_avg, 0);
            end
            if (i == 5) begin
                check("lock_edge5", locked, 1);
                check("avg_edge5", period_avg, 1250);
            end
        end
        check("wave_pulses", pv_seen - pv_base, 9);
        check("wave_period", period, 1250);
        check("wave_avg", period_avg, 1250);

        // single glitch while locked
        next_edge(300);
        next_edge(1250);
        settle();
        check("glitch1_err", err_cnt, 1);
        check("glitch1_locked", locked, 1);
        // two consecutive glitches
        next_edge(300);
        next_edge(300);
        settle();
        check("glitch2_err", err_cnt, 3);
        check("glitch2_locked", locked, 0);
        check("glitch2_state", state_dbg, 1);

        // relock, then stop the carrier
        for (int i = 0; i < 4; i++) next_edge(1250);
        settle();
        check("relock", locked, 1);
        wait_to(last_rise + 625);
        carrier_in = 1'b0;
        wait_to(last_rise + 3 + 8191);
        check("pre_timeout_lost", carrier_lost, 0);
        check("pre_timeout_locked", locked, 1);
        wait_to(last_rise + 3 + 8192);
        check("timeout_lost", carrier_lost, 1);
        check("timeout_locked", locked, 0);
        wait_to(last_rise + 9000);
        carrier_in = 1'b1;
        last_rise = last_rise + 9000;
        settle();
        check("regain_lost", carrier_lost, 0);
        check("regain_state", state_dbg, 1);

        // range boundaries in acquisition
        pv_base = pv_seen;
        next_edge(500);
        settle();
        check("bound_500", period, 500);
        next_edge(5000);
        settle();
        check("bound_5000", period, 5000);
        next_edge(499);
        settle();
        check("bound_499", period, 5000);
        next_edge(5001);
        settle();
        check("bound_5001", period, 5000);
        check("bound_pulses", pv_seen - pv_base, 2);
        for (int i = 1; i <= 4; i++) begin
            next_edge(500);
            settle();
            check("bound_relock", locked, (i == 4) ? 1 : 0);
        end

        // heartbeat over 40 locked periods
        for (int i = 1; i <= 40; i++) begin
            next_edge(500);
            if (i == 20) begin
                settle();
                check("hb_mid", heartbeat, 1);
            end
        end
        settle();
        check("hb_end", heartbeat, 0);

        // bring err_cnt to 5 while staying locked, then reset
        next_edge(300);
        next_edge(500);
        next_edge(300);
        next_edge(500);
        settle();
        check("err5", err_cnt, 5);
        check("err5_locked", locked, 1);
        wait_to(last_rise + 250);
        carrier_in = 1'b0;
        wait_to(last_rise + 260);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("mid_reset");
        for (int i = 1; i <= 5; i++) begin
            next_edge(500);
            settle();
            check("reset_relock", locked, (i == 5) ? 1 : 0);
        end

        // randomized periods, some out of range
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) rp = $urandom_range(300, 499);
            else rp = $urandom_range(500, 1000);
            next_edge(rp);
        end
        wait_to(cyc + 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
